// File: rtl/stopwatch_pkg.sv
// Shared types and default parameters for the stopwatch control stage.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int DIV_DEF        = 10;

endpackage

// File: rtl/debounce_edge.sv
// Button conditioner: 2-flop synchronizer, stability counter, debounced
// level and a one-cycle pulse on each qualified press (0->1 only).
module debounce_edge #(
  parameter int DEB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // Count consecutive cycles where the synchronized input disagrees with the
  // debounced level; flip the level once it has disagreed long enough.
  always_comb begin
    sync_d  = {sync_q[0], i_btn};
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset discards any in-flight qualification.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and clear buttons drive an
// IDLE/RUN/PAUSE machine that gates a prescaled count-enable pulse and
// issues a one-cycle clear pulse to the downstream counter chain.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DIV        = DIV_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_start_stop,
  input  logic i_btn_clear,
  output logic o_en,
  output logic o_clear,
  output logic o_running
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic press_ss;
  logic press_cl;

  debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start_stop (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_start_stop),
    .o_press (press_ss)
  );

  debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_clear),
    .o_press (press_cl)
  );

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          en_q, en_d;
  logic          clear_q, clear_d;
  logic          running_q, running_d;

  // Next state, prescaler and output decode; clear always beats start/stop.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    if (press_cl) begin
      state_d = S_IDLE;
      clear_d = 1'b1;
    end else if (press_ss) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end

    // Prescaler only advances across edges spent entirely in RUN, so the
    // pulse phase survives a pause and restarts from zero out of IDLE.
    pre_d = pre_q;
    if (state_d == S_IDLE) begin
      pre_d = '0;
    end else if ((state_q == S_RUN) && (state_d == S_RUN)) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end

    running_d = (state_d == S_RUN);
    en_d      = running_d && (pre_d == PRE_LAST);
  end

  // FSM, prescaler and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      en_q      <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      en_q      <= en_d;
      clear_q   <= clear_d;
      running_q <= running_d;
    end
  end

  assign o_en      = en_q;
  assign o_clear   = clear_q;
  assign o_running = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// button activity, compared every cycle against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bss = 1'b0;
  logic bcl = 1'b0;
  logic o_en, o_clear, o_running;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEB_CYCLES(DEB), .DIV(DIV)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_btn_start_stop (bss),
    .i_btn_clear      (bcl),
    .o_en             (o_en),
    .o_clear          (o_clear),
    .o_running        (o_running)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0b expected %0b", tag, cyc, got, exp);
    end
  endtask

  // Behavioural model. Each button: raw value reaches the "seen" stage two
  // edges later; the debounced level changes once the last DEB seen values
  // all disagree with it (history kept as a shift word of seen samples).
  bit          m_s1[2], m_s2[2], m_deb[2], m_press[2];
  int unsigned m_hist[2];
  int          m_hlen[2];
  int          m_mode;   // 0 idle, 1 run, 2 pause
  int          m_phase;  // cycles of RUN modulo DIV
  bit          m_en, m_clear, m_run;

  task automatic model_step(input bit r, input bit raw_ss, input bit raw_cl);
    bit p_ss, p_cl, flip;
    bit raw[2];
    int old_mode;
    int unsigned mask;
    mask   = (32'd1 << DEB) - 1;
    raw[0] = raw_ss;
    raw[1] = raw_cl;
    if (r) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_press[b] = 0;
        m_hist[b] = 0; m_hlen[b] = 0;
      end
      m_mode = 0; m_phase = 0; m_en = 0; m_clear = 0; m_run = 0;
    end else begin
      p_ss = m_press[0];
      p_cl = m_press[1];
      for (int b = 0; b < 2; b++) begin
        m_hist[b] = (m_hist[b] << 1) | 32'(m_s2[b]);
        m_hlen[b]++;
        flip = (m_hlen[b] >= DEB) &&
               ((m_hist[b] & mask) == (m_deb[b] ? 32'd0 : mask));
        m_press[b] = flip && !m_deb[b];
        if (flip) begin
          m_deb[b]  = !m_deb[b];
          m_hist[b] = 0;
          m_hlen[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
      old_mode = m_mode;
      m_clear  = 0;
      if (p_cl) begin
        m_mode  = 0;
        m_clear = 1;
      end else if (p_ss) begin
        m_mode = (m_mode == 1) ? 2 : 1;
      end
      if (m_mode == 0) m_phase = 0;
      else if (old_mode == 1 && m_mode == 1) m_phase = (m_phase + 1) % DIV;
      m_run = (m_mode == 1);
      m_en  = m_run && (m_phase == DIV - 1);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, check at negedge.
  task automatic step(input bit r, input bit a, input bit c);
    rst = r;
    bss = a;
    bcl = c;
    @(posedge clk);
    model_step(r, a, c);
    @(negedge clk);
    cyc++;
    check_eq("o_en", o_en, m_en);
    check_eq("o_clear", o_clear, m_clear);
    check_eq("o_running", o_running, m_run);
    check_eq("en_clear_excl", o_en & o_clear, 1'b0);
  endtask

  task automatic hold(input bit a, input bit c, input int n);
    for (int i = 0; i < n; i++) step(0, a, c);
  endtask

  initial begin
    bit seg_r, seg_a, seg_c;
    int seg_len;
    bit bounce [7];

    @(negedge clk);

    // Reset with buttons toggling.
    $display("txn reset: 2 edges, buttons toggling");
    step(1, 1, 0);
    step(1, 0, 1);
    check_eq("reset_en", o_en, 1'b0);
    check_eq("reset_clear", o_clear, 1'b0);
    check_eq("reset_running", o_running, 1'b0);
    hold(0, 0, 3);

    // Start: raw 1 sampled first at edge e0 (step index 0).
    $display("txn start: start_stop held 10 cycles");
    for (int k = 0; k < 25; k++) begin
      step(0, k < 10, 0);
      check_eq("start_running", o_running, k >= 6);
      check_eq("start_en", o_en, (k >= 8) && ((k - 8) % 3 == 0));
    end

    // Clear back to IDLE, then a bounce shorter than the qualify window.
    $display("txn clear: clear held 6 cycles");
    hold(0, 1, 6);
    hold(0, 0, 8);
    check_eq("cleared_running", o_running, 1'b0);
    $display("txn bounce: 1,1,1,0,1,1,0");
    bounce = '{1, 1, 1, 0, 1, 1, 0};
    for (int k = 0; k < 7; k++) step(0, bounce[k], 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0);
      check_eq("bounce_running", o_running, 1'b0);
      check_eq("bounce_en", o_en, 1'b0);
    end

    // Run, pause, resume.
    $display("txn run/pause/resume");
    hold(1, 0, 6); hold(0, 0, 7);
    hold(1, 0, 6); hold(0, 0, 9);
    hold(1, 0, 6); hold(0, 0, 9);

    // Both buttons rise together while running.
    $display("txn clear priority: both buttons together");
    hold(1, 1, 7);
    hold(0, 0, 8);
    check_eq("prio_running", o_running, 1'b0);

    // Reset in RUN with start_stop held.
    $display("txn mid-run reset");
    hold(1, 0, 6); hold(0, 0, 4);
    hold(1, 0, 3);
    step(1, 1, 0);
    check_eq("midrst_running", o_running, 1'b0);
    check_eq("midrst_en", o_en, 1'b0);
    hold(1, 0, 12);
    hold(0, 0, 6);

    // Random segments of held button levels.
    for (int s = 0; s < 400; s++) begin
      seg_r   = ($urandom_range(0, 39) == 0);
      seg_a   = $urandom_range(0, 1);
      seg_c   = ($urandom_range(0, 7) == 0);
      seg_len = $urandom_range(1, 10);
      $display("txn rand %0d: rst=%0b ss=%0b cl=%0b len=%0d", s, seg_r, seg_a, seg_c, seg_len);
      if (seg_r) step(1, seg_a, seg_c);
      else hold(seg_a, seg_c, seg_len);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
